// File: rtl/triloc_pkg.sv
// Shared definitions for the trilateration sequencer: default coordinate
// width, FSM state encoding, arithmetic width helpers, pair ordering and
// ISX_LAT bounds.
package triloc_pkg;

   localparam int DEFAULT_N = 8;

   // Datapath latency bounds; the WAIT counter is sized for the upper bound.
   localparam int ISX_LAT_MIN = 1;
   localparam int ISX_LAT_MAX = 15;
   localparam int CNT_W       = 4;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE  = 3'd1,
      S_WAIT   = 3'd2,
      S_SCORE  = 3'd3,
      S_SELECT = 3'd4
   } state_t;

   // Width of a coordinate difference between two N+2-bit candidates.
   function automatic int diff_w(input int n);
      return n + 3;
   endfunction

   // Width of an absolute difference and of an L1 distance.
   function automatic int l1_w(input int n);
      return n + 4;
   endfunction

   // Width of a candidate score (sum of two L1 minima).
   function automatic int score_w(input int n);
      return n + 5;
   endfunction

   localparam int DIFF_W  = DEFAULT_N + 3;
   localparam int L1_W    = DEFAULT_N + 4;
   localparam int SCORE_W = DEFAULT_N + 5;

   // Pair order: P0=(A0,A1), P1=(A1,A2), P2=(A0,A2); first anchor goes on K.
   function automatic logic [1:0] pair_k(input logic [1:0] p);
      return (p == 2'd1) ? 2'd1 : 2'd0;
   endfunction

   function automatic logic [1:0] pair_l(input logic [1:0] p);
      return (p == 2'd0) ? 2'd1 : 2'd2;
   endfunction

endpackage

// File: rtl/trilat_l1min.sv
// Minimum L1 distance from one point to the nearer of two candidates.
// Purely combinational; the caller registers the result.
module trilat_l1min
   import triloc_pkg::*;
#(
   parameter int N = DEFAULT_N
) (
   input  logic signed [N+1:0] px_i,
   input  logic signed [N+1:0] py_i,
   input  logic signed [N+1:0] ax_i,
   input  logic signed [N+1:0] ay_i,
   input  logic signed [N+1:0] bx_i,
   input  logic signed [N+1:0] by_i,
   output logic [N+3:0]        l1_min_o
);

   localparam int DW = diff_w(N);
   localparam int LW = l1_w(N);

   logic signed [N+1:0] cx [2];
   logic signed [N+1:0] cy [2];
   logic signed [DW-1:0] dx [2];
   logic signed [DW-1:0] dy [2];
   logic [LW-1:0] abs_x [2];
   logic [LW-1:0] abs_y [2];
   logic [LW-1:0] l1 [2];

   assign cx[0] = ax_i;
   assign cy[0] = ay_i;
   assign cx[1] = bx_i;
   assign cy[1] = by_i;

   // One sign-extended difference/abs/sum chain per candidate.
   for (genvar gi = 0; gi < 2; gi++) begin : g_cand
      assign dx[gi]    = DW'(px_i) - DW'(cx[gi]);
      assign dy[gi]    = DW'(py_i) - DW'(cy[gi]);
      assign abs_x[gi] = dx[gi][DW-1] ? LW'(-dx[gi]) : LW'(dx[gi]);
      assign abs_y[gi] = dy[gi][DW-1] ? LW'(-dy[gi]) : LW'(dy[gi]);
      assign l1[gi]    = abs_x[gi] + abs_y[gi];
   end

   assign l1_min_o = (l1[1] < l1[0]) ? l1[1] : l1[0];

endmodule

// File: rtl/trilat_seq.sv
// Trilateration sequencer: feeds three anchor-circle pairs through an
// external intersection datapath, captures both candidates per pair, scores
// the two P0 candidates against the P1/P2 candidates by L1 distance and
// outputs the better one. Define TRILAT_SEQ_SCORE_EN to add a `score`
// output carrying the winning score.
module trilat_seq
   import triloc_pkg::*;
#(
   parameter int N       = DEFAULT_N,
   parameter int ISX_LAT = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic signed [N-1:0] x0,
   input  logic signed [N-1:0] y0,
   input  logic signed [N-1:0] x1,
   input  logic signed [N-1:0] y1,
   input  logic signed [N-1:0] x2,
   input  logic signed [N-1:0] y2,
   input  logic [N:0]         r0,
   input  logic [N:0]         r1,
   input  logic [N:0]         r2,
   output logic               busy,
   output logic               done,
   output logic signed [N+1:0] xP,
   output logic signed [N+1:0] yP,
   output logic signed [N-1:0] ix_xK,
   output logic signed [N-1:0] ix_yK,
   output logic signed [N-1:0] ix_xL,
   output logic signed [N-1:0] ix_yL,
   output logic [N:0]         ix_rK,
   output logic [N:0]         ix_rL,
   input  logic signed [N+1:0] ix_x1P,
   input  logic signed [N+1:0] ix_y1P,
   input  logic signed [N+1:0] ix_x2P,
   input  logic signed [N+1:0] ix_y2P
`ifdef TRILAT_SEQ_SCORE_EN
   ,
   output logic [N+4:0]       score
`endif
);

   localparam int LW = l1_w(N);
   localparam int SW = score_w(N);
   // Out-of-range latencies are clamped so the WAIT counter stays valid.
   localparam int LAT_C = (ISX_LAT < ISX_LAT_MIN) ? ISX_LAT_MIN :
                          (ISX_LAT > ISX_LAT_MAX) ? ISX_LAT_MAX : ISX_LAT;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT_C - 1);

   state_t state_q, state_d;
   logic [1:0] pair_q, pair_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic signed [N-1:0] in_x [3];
   logic signed [N-1:0] in_y [3];
   logic [N:0] in_r [3];
   logic signed [N-1:0] anc_x_q [3];
   logic signed [N-1:0] anc_y_q [3];
   logic [N:0] anc_r_q [3];
   logic signed [N-1:0] src_x [3];
   logic signed [N-1:0] src_y [3];
   logic [N:0] src_r [3];

   logic signed [N+1:0] c1x_q [3];
   logic signed [N+1:0] c1y_q [3];
   logic signed [N+1:0] c2x_q [3];
   logic signed [N+1:0] c2y_q [3];

   logic signed [N-1:0] ix_xk_q, ix_yk_q, ix_xl_q, ix_yl_q;
   logic [N:0] ix_rk_q, ix_rl_q;
   logic busy_q, done_q;
   logic signed [N+1:0] xp_q, yp_q;

   logic accept, capture;
   logic [1:0] k_sel, l_sel;
   logic [LW-1:0] l1m [4];
   logic [SW-1:0] score1, score2;
   logic pick1;

   assign in_x[0] = x0;
   assign in_y[0] = y0;
   assign in_r[0] = r0;
   assign in_x[1] = x1;
   assign in_y[1] = y1;
   assign in_r[1] = r1;
   assign in_x[2] = x2;
   assign in_y[2] = y2;
   assign in_r[2] = r2;

   assign accept  = (state_q == S_IDLE) && start;
   assign capture = (state_q == S_WAIT) && (cnt_q == CNT_LAST);

   // The P0 issue happens on the accepting edge, before the latch holds the
   // anchors, so the live inputs are used while still in IDLE.
   for (genvar gi = 0; gi < 3; gi++) begin : g_src
      assign src_x[gi] = (state_q == S_IDLE) ? in_x[gi] : anc_x_q[gi];
      assign src_y[gi] = (state_q == S_IDLE) ? in_y[gi] : anc_y_q[gi];
      assign src_r[gi] = (state_q == S_IDLE) ? in_r[gi] : anc_r_q[gi];
   end

   assign k_sel = pair_k(pair_d);
   assign l_sel = pair_l(pair_d);

   // Next-state logic: three ISSUE/WAIT rounds, then SCORE and SELECT.
   always_comb begin
      state_d = state_q;
      pair_d  = pair_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ISSUE;
               pair_d  = 2'd0;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
            cnt_d   = '0;
         end
         S_WAIT: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (pair_q == 2'd2) begin
                  state_d = S_SCORE;
               end else begin
                  state_d = S_ISSUE;
                  pair_d  = pair_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SCORE:  state_d = S_SELECT;
         S_SELECT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // FSM, pair index and WAIT counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pair_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pair_q  <= pair_d;
         cnt_q   <= cnt_d;
      end
   end

   // Anchor latch on accept and per-pair candidate capture on the last WAIT cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            anc_x_q[i] <= '0;
            anc_y_q[i] <= '0;
            anc_r_q[i] <= '0;
            c1x_q[i]   <= '0;
            c1y_q[i]   <= '0;
            c2x_q[i]   <= '0;
            c2y_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (accept) begin
               anc_x_q[i] <= in_x[i];
               anc_y_q[i] <= in_y[i];
               anc_r_q[i] <= in_r[i];
            end
            if (capture && (pair_q == 2'(i))) begin
               c1x_q[i] <= ix_x1P;
               c1y_q[i] <= ix_y1P;
               c2x_q[i] <= ix_x2P;
               c2y_q[i] <= ix_y2P;
            end
         end
      end
   end

   // Load the next pair onto the datapath ports as ISSUE is entered; hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         ix_xk_q <= '0;
         ix_yk_q <= '0;
         ix_xl_q <= '0;
         ix_yl_q <= '0;
         ix_rk_q <= '0;
         ix_rl_q <= '0;
      end else if (state_d == S_ISSUE) begin
         ix_xk_q <= src_x[k_sel];
         ix_yk_q <= src_y[k_sel];
         ix_xl_q <= src_x[l_sel];
         ix_yl_q <= src_y[l_sel];
         ix_rk_q <= src_r[k_sel];
         ix_rl_q <= src_r[l_sel];
      end
   end

   // Four min-L1 terms: P0 candidate (gi/2) against the P1 or P2 candidates.
   for (genvar gi = 0; gi < 4; gi++) begin : g_l1
      localparam int CAND = gi / 2;
      localparam int PR   = 1 + (gi % 2);
      trilat_l1min #(.N(N)) u_l1min (
         .px_i    ((CAND == 0) ? c1x_q[0] : c2x_q[0]),
         .py_i    ((CAND == 0) ? c1y_q[0] : c2y_q[0]),
         .ax_i    (c1x_q[PR]),
         .ay_i    (c1y_q[PR]),
         .bx_i    (c2x_q[PR]),
         .by_i    (c2y_q[PR]),
         .l1_min_o(l1m[gi])
      );
   end

   assign score1 = SW'(l1m[0]) + SW'(l1m[1]);
   assign score2 = SW'(l1m[2]) + SW'(l1m[3]);
   assign pick1  = (score1 <= score2);   // tie goes to candidate 1

   // Status flags and result: the winner is registered on the SCORE->SELECT
   // edge so xP/yP are already valid in the done cycle, then held.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         xp_q   <= '0;
         yp_q   <= '0;
      end else begin
         busy_q <= (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_SCORE);
         done_q <= (state_q == S_SCORE);
         if (state_q == S_SCORE) begin
            xp_q <= pick1 ? c1x_q[0] : c2x_q[0];
            yp_q <= pick1 ? c1y_q[0] : c2y_q[0];
         end
      end
   end

`ifdef TRILAT_SEQ_SCORE_EN
   logic [SW-1:0] score_q;

   // Winning score, registered alongside xP/yP.
   always_ff @(posedge clk) begin
      if (rst) begin
         score_q <= '0;
      end else if (state_q == S_SCORE) begin
         score_q <= pick1 ? score1 : score2;
      end
   end

   assign score = score_q;
`endif

   assign busy  = busy_q;
   assign done  = done_q;
   assign xP    = xp_q;
   assign yP    = yp_q;
   assign ix_xK = ix_xk_q;
   assign ix_yK = ix_yk_q;
   assign ix_xL = ix_xl_q;
   assign ix_yL = ix_yl_q;
   assign ix_rK = ix_rk_q;
   assign ix_rL = ix_rl_q;

endmodule

// File: tb/tb_trilat_seq.sv
// Directed bench for trilat_seq: two instances (ISX_LAT=1 and 4), each with a
// lookup-table intersection stub delayed by ISX_LAT cycles. Optional score
// port is checked when TRILAT_SEQ_SCORE_EN is defined.
module tb_trilat_seq;

   localparam int N = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic start_s [2];
   logic signed [7:0] ax [3];
   logic signed [7:0] ay [3];
   logic [8:0] ar [3];
   int mode;   // 0 = nominal geometry, 1 = tie stub

   logic busy_s [2];
   logic done_s [2];
   logic signed [9:0] xP_s [2];
   logic signed [9:0] yP_s [2];
   logic signed [7:0] ix_xK_s [2];
   logic signed [7:0] ix_yK_s [2];
   logic signed [7:0] ix_xL_s [2];
   logic signed [7:0] ix_yL_s [2];
   logic [8:0] ix_rK_s [2];
   logic [8:0] ix_rL_s [2];
   logic signed [9:0] x1P_s [2];
   logic signed [9:0] y1P_s [2];
   logic signed [9:0] x2P_s [2];
   logic signed [9:0] y2P_s [2];
   logic [39:0] cand_s [2];
`ifdef TRILAT_SEQ_SCORE_EN
   logic [12:0] score_s [2];
`endif

   int n_chk  = 0;
   int n_fail = 0;

   // Hand-computed circle intersections for the nominal anchors
   // A0=(0,0) A1=(6,0) A2=(3,9), all r=5, keyed on the K/L centres.
   function automatic logic [39:0] lookup(input logic [31:0] b, input int m);
      int kx, ky, lx, ly, p;
      int v [4];
      kx = int'($signed(b[31:24]));
      ky = int'($signed(b[23:16]));
      lx = int'($signed(b[15:8]));
      ly = int'($signed(b[7:0]));
      p = -1;
      if (kx == 0 && ky == 0 && lx == 6 && ly == 0) p = 0;
      else if (kx == 6 && ky == 0 && lx == 3 && ly == 9) p = 1;
      else if (kx == 0 && ky == 0 && lx == 3 && ly == 9) p = 2;
      v = '{100, 100, 100, 100};
      if (m == 0) begin
         if (p == 0) v = '{3, 4, 3, -4};
         else if (p == 1) v = '{6, 5, 3, 4};
         else if (p == 2) v = '{3, 4, 0, 5};
      end else begin
         if (p == 0) v = '{10, 10, -10, -10};
         else if (p >= 1) v = '{0, 10, 0, -10};
      end
      return {10'(v[0]), 10'(v[1]), 10'(v[2]), 10'(v[3])};
   endfunction

   for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      localparam int LAT = (gi == 0) ? 1 : 4;
      logic [31:0] hist [LAT];

      trilat_seq #(.N(N), .ISX_LAT(LAT)) u_dut (
         .clk   (clk),
         .rst   (rst),
         .start (start_s[gi]),
         .x0    (ax[0]),
         .y0    (ay[0]),
         .x1    (ax[1]),
         .y1    (ay[1]),
         .x2    (ax[2]),
         .y2    (ay[2]),
         .r0    (ar[0]),
         .r1    (ar[1]),
         .r2    (ar[2]),
         .busy  (busy_s[gi]),
         .done  (done_s[gi]),
         .xP    (xP_s[gi]),
         .yP    (yP_s[gi]),
         .ix_xK (ix_xK_s[gi]),
         .ix_yK (ix_yK_s[gi]),
         .ix_xL (ix_xL_s[gi]),
         .ix_yL (ix_yL_s[gi]),
         .ix_rK (ix_rK_s[gi]),
         .ix_rL (ix_rL_s[gi]),
         .ix_x1P(x1P_s[gi]),
         .ix_y1P(y1P_s[gi]),
         .ix_x2P(x2P_s[gi]),
         .ix_y2P(y2P_s[gi])
`ifdef TRILAT_SEQ_SCORE_EN
         ,
         .score (score_s[gi])
`endif
      );

      // Stub datapath: result reflects the ix_* inputs of LAT cycles ago.
      always @(posedge clk) begin
         hist[0] <= {ix_xK_s[gi], ix_yK_s[gi], ix_xL_s[gi], ix_yL_s[gi]};
         for (int i = 1; i < LAT; i++) hist[i] <= hist[i-1];
      end

      assign cand_s[gi] = lookup(hist[LAT-1], mode);
      assign x1P_s[gi]  = cand_s[gi][39:30];
      assign y1P_s[gi]  = cand_s[gi][29:20];
      assign x2P_s[gi]  = cand_s[gi][19:10];
      assign y2P_s[gi]  = cand_s[gi][9:0];
   end

   task automatic chk(input string tag, input logic signed [63:0] got,
                      input logic signed [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_nominal();
      ax = '{8'sd0, 8'sd6, 8'sd3};
      ay = '{8'sd0, 8'sd0, 8'sd9};
      ar = '{9'd5, 9'd5, 9'd5};
   endtask

   function automatic logic [49:0] ix_bundle(input int s);
      return {ix_xK_s[s], ix_yK_s[s], ix_xL_s[s], ix_yL_s[s], ix_rK_s[s], ix_rL_s[s]};
   endfunction

   // Runs ncyc cycles on instance sel. sched bit t = start in cycle t.
   // rst_cyc/chg_cyc: cycle to pulse reset / scramble anchors (-1 = never).
   task automatic run_seq(input int sel, input int ncyc, input logic [63:0] sched,
                          input int rst_cyc, input int chg_cyc,
                          input int ex_x, input int ex_y, input int ex_sc);
      int lat, d, win, acc, zchk, p, kk, ll;
      int lx [3];
      int ly [3];
      int lr [3];
      logic exp_busy, exp_done;
      logic [49:0] ix_exp;
      lat  = (sel == 0) ? 1 : 4;
      win  = 3 * (1 + lat);
      d    = win + 2;
      acc  = -1;
      zchk = -1;
      lx = '{0, 0, 0};
      ly = '{0, 0, 0};
      lr = '{0, 0, 0};
      for (int t = 0; t < ncyc; t++) begin
         rst = (t == rst_cyc);
         start_s[sel] = sched[t];
         start_s[1-sel] = 1'b0;
         if (t == chg_cyc) begin
            ax = '{8'sd50, 8'sd51, 8'sd52};
            ay = '{-8'sd50, -8'sd51, -8'sd52};
            ar = '{9'd77, 9'd78, 9'd79};
         end
         exp_busy = (acc >= 0) && (t > acc) && (t < acc + d);
         exp_done = (acc >= 0) && (t == acc + d);
         chk($sformatf("busy%0d@%0d", sel, t), busy_s[sel], exp_busy);
         chk($sformatf("done%0d@%0d", sel, t), done_s[sel], exp_done);
         if (exp_done) begin
            chk($sformatf("xP%0d@%0d", sel, t), xP_s[sel], ex_x);
            chk($sformatf("yP%0d@%0d", sel, t), yP_s[sel], ex_y);
`ifdef TRILAT_SEQ_SCORE_EN
            chk($sformatf("score%0d@%0d", sel, t), score_s[sel], ex_sc);
`else
            if (ex_sc < 0) $display("note: negative score expectation ignored");
`endif
         end
         if ((acc >= 0) && (t == acc + d + 1)) begin
            chk($sformatf("xP_hold%0d@%0d", sel, t), xP_s[sel], ex_x);
            chk($sformatf("yP_hold%0d@%0d", sel, t), yP_s[sel], ex_y);
         end
         if (t == zchk) begin
            chk($sformatf("rst_xP%0d@%0d", sel, t), xP_s[sel], 0);
            chk($sformatf("rst_yP%0d@%0d", sel, t), yP_s[sel], 0);
            chk($sformatf("rst_ix%0d@%0d", sel, t), ix_bundle(sel), 0);
         end
         if ((acc >= 0) && (t > acc) && (t <= acc + win)) begin
            p  = (t - acc - 1) / (1 + lat);
            kk = (p == 1) ? 1 : 0;
            ll = (p == 0) ? 1 : 2;
            ix_exp = {8'(lx[kk]), 8'(ly[kk]), 8'(lx[ll]), 8'(ly[ll]),
                      9'(lr[kk]), 9'(lr[ll])};
            chk($sformatf("ix%0d_p%0d@%0d", sel, p, t), ix_bundle(sel), ix_exp);
         end
         // Reference model of the handshake for the next cycle.
         if (t == rst_cyc) begin
            acc  = -1;
            zchk = t + 1;
         end else if (sched[t] && ((acc < 0) || (t > acc + d))) begin
            acc = t;
            for (int k = 0; k < 3; k++) begin
               lx[k] = int'(ax[k]);
               ly[k] = int'(ay[k]);
               lr[k] = int'(ar[k]);
            end
         end
         tick();
      end
      start_s[sel] = 1'b0;
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [63:0] sch;
      rst = 1'b1;
      start_s[0] = 1'b0;
      start_s[1] = 1'b0;
      mode = 0;
      set_nominal();
      repeat (3) tick();
      for (int s = 0; s < 2; s++) begin
         chk($sformatf("reset_busy%0d", s), busy_s[s], 0);
         chk($sformatf("reset_done%0d", s), done_s[s], 0);
         chk($sformatf("reset_xP%0d", s), xP_s[s], 0);
         chk($sformatf("reset_yP%0d", s), yP_s[s], 0);
         chk($sformatf("reset_ix%0d", s), ix_bundle(s), 0);
      end
      rst = 1'b0;
      tick();

      // Nominal fix, ISX_LAT=1: done at cycle 8, (3,4), score 0.
      sch = 64'd1;
      run_seq(0, 12, sch, -1, -1, 3, 4, 0);
      $display("txn nominal lat1 done");

      // Tie: both P0 candidates score 20 -> candidate 1 (10,10).
      mode = 1;
      run_seq(0, 12, sch, -1, -1, 10, 10, 20);
      mode = 0;
      $display("txn tie lat1 done");

      // Handshake: starts at 0,3,8,9 -> accepted at 0 and 9, done at 8 and 17.
      sch = 64'd0;
      sch[0] = 1'b1;
      sch[3] = 1'b1;
      sch[8] = 1'b1;
      sch[9] = 1'b1;
      run_seq(0, 22, sch, -1, -1, 3, 4, 0);
      $display("txn handshake lat1 done");

      // Reset at cycle 5 aborts; start at 7 completes at 15.
      sch = 64'd0;
      sch[0] = 1'b1;
      sch[7] = 1'b1;
      run_seq(0, 20, sch, 5, -1, 3, 4, 0);
      $display("txn reset-mid-fix lat1 done");

      // ISX_LAT=4 with anchors scrambled at cycle 6: done at 17, (3,4).
      sch = 64'd1;
      run_seq(1, 22, sch, -1, 6, 3, 4, 0);
      set_nominal();
      $display("txn stall+anchor-change lat4 done");

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/trilat_seq.md
TRILAT_SEQ -- requirements
Module: trilat_seq

Interface
REQ-001 Parameter N, default 8: anchor coordinate width; coordinates are N-bit two's complement, radii are N+1-bit unsigned.
REQ-002 Parameter ISX_LAT, default 1, range 1..15: cycles from datapath input change to valid datapath output.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 Ports, in order:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request a fix; honoured in IDLE only
- x0,y0,x1,y1,x2,y2  in  N each  anchor A0..A2 coordinates
- r0,r1,r2  in  N+1 each  anchor ranges
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse; result valid
- xP,yP  out  N+2 signed  selected position
- ix_xK,ix_yK,ix_xL,ix_yL  out  N each  intersection datapath circle centres
- ix_rK,ix_rL  out  N+1 each  intersection datapath radii
- ix_x1P,ix_y1P,ix_x2P,ix_y2P  in  N+2 signed  datapath candidates

Function
REQ-005 On start in IDLE, the block latches all nine anchor inputs; later anchor changes have no effect until the next accepted start.
REQ-006 Pair order SHALL be P0=(A0,A1), P1=(A1,A2), P2=(A0,A2), with the first anchor on the K ports.
REQ-007 The FSM SHALL use states IDLE, ISSUE, WAIT, SCORE and SELECT.
REQ-008 State transitions:
- IDLE->ISSUE on start.
- ISSUE: drive the registered pair onto the ix_* ports for 1 cycle, then ->WAIT.
- WAIT: hold the ix_* ports for ISX_LAT cycles, capturing both candidates on the last WAIT cycle.
- After WAIT: ->ISSUE for the next pair, or ->SCORE after P2.
- SCORE (1 cycle) ->SELECT (1 cycle) ->IDLE.
REQ-009 The ix_* outputs SHALL be registered and SHALL stay stable through ISSUE and WAIT of each pair.
REQ-010 Latency: with start accepted at cycle 0, done SHALL be high in cycle 3*(1+ISX_LAT)+2 (cycle 8 for ISX_LAT=1).
REQ-011 The score of P0 candidate c SHALL equal (min L1 distance from c to the two P1 candidates) plus (min L1 distance from c to the two P2 candidates).
REQ-012 Arithmetic widths:
- Differences: N+3 signed.
- Absolute values and L1 terms: N+4 unsigned.
- Score: N+5 unsigned.
- No saturation is needed at these widths.
REQ-013 SELECT SHALL register the P0 candidate with the lower score into xP/yP and pulse done; on a tie, candidate 1 (x1P,y1P) wins.
REQ-014 xP/yP SHALL hold their value until the next SELECT.
REQ-015 busy SHALL be high in ISSUE, WAIT and SCORE, and low in IDLE and in the SELECT (done) cycle.
REQ-016 A start while busy SHALL be ignored, with no queuing; a start in the done cycle SHALL be ignored.
REQ-017 A start in the cycle after done SHALL be accepted.

Reset
REQ-018 rst SHALL force IDLE, and zero busy, done, xP, yP, all ix_* outputs, the captured candidates and the WAIT counter.
REQ-019 rst asserted mid-operation SHALL abort the fix, with no done pulse, and SHALL take priority over start.

Configuration
REQ-020 Macro TRILAT_SEQ_SCORE_EN defined: an added output port score (N+5 unsigned, reset 0) SHALL carry the winning score, registered in SELECT.
REQ-021 Macro TRILAT_SEQ_SCORE_EN undefined: the score port and its register SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-022 A shared package triloc_pkg SHALL hold:
- the default N;
- the FSM state enum;
- localparams for difference, L1-term and score widths as functions of N;
- the ISX_LAT bounds.
REQ-023 The min-L1 computation SHALL live in one sub-module, trilat_l1min, which takes one point and two candidates and returns the minimum L1 distance. It SHALL be instantiated four times, combinationally, and registered in SCORE.
REQ-024 The intersection datapath SHALL be instantiated outside this block.

Verification
REQ-025 Nominal fix: A0=(0,0,r5), A1=(6,0,r5), A2=(3,9,r5), ISX_LAT=1, with the real datapath attached -> done at cycle 8 and (xP,yP)=(3,4), within datapath rounding.
REQ-026 Tie case: a stub datapath returns P0 candidates (10,10)/(-10,-10) and P1=P2 candidates (0,10)/(0,-10), giving equal scores -> output (10,10).
REQ-027 Busy and restart handshake:
- A start pulse at cycles 3 and 8 is ignored.
- A start at cycle 9 is accepted, with done at cycle 17.
- busy is low only in IDLE and in the done cycles.
REQ-028 Reset mid-fix: rst at cycle 5 -> all outputs 0 at cycle 6 and no done.
- A start at cycle 7 then completes normally at cycle 15.
REQ-029 Stall and anchor-change check: ISX_LAT=4 -> done at cycle 17.
- ix_* ports are checked stable across each ISSUE+WAIT window.
- Anchor inputs changed mid-fix do not alter the result.
REQ-030 Macro build: with TRILAT_SEQ_SCORE_EN defined, the nominal fix yields score=0 (all three pairs share (3,4)).
- The same bench without the macro compiles without the score port.
